echo_capture_ctrl: RTL

//  Write-side controller for the echo sample buffer (dualram_rdreg instance).

---
 rtl/echo_pkg.sv | 15 +
 rtl/echo_capture_ctrl_trig_edge.sv | 22 ++
 rtl/echo_capture_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/echo_pkg.sv
// Shared definitions for the echo capture write-side controller:
// controller state encoding and the decimation field width.
package echo_pkg;

    localparam int DECIM_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DELAY,
        ST_CAPTURE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/echo_capture_ctrl_trig_edge.sv
// Registers the transmit trigger level and produces a one-cycle pulse
// in the cycle where the level is high but was low the cycle before.
module trig_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_trig,
    output logic o_rise
);

    logic trig_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= i_trig;
        end
    end

    assign o_rise = i_trig & ~trig_q;

endmodule

// File: rtl/echo_capture_ctrl.sv
// Write-side controller for the echo sample buffer: arm, wait for the
// trigger edge, count the delay, then write depth+1 decimated samples.
module echo_capture_ctrl
    import echo_pkg::*;
#(
    parameter int ASIZE = 13,
    parameter int DSIZE = 8,
    parameter int DLYW  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_arm,
    input  logic               i_abort,
    input  logic               i_trig,
    input  logic [DLYW-1:0]    i_delay,
    input  logic [ASIZE-1:0]   i_depth,
    input  logic [DECIM_W-1:0] i_decim,
    input  logic               i_adc_valid,
    input  logic [DSIZE-1:0]   i_adc_data,
    input  logic               i_ack,
    output logic               o_wren,
    output logic [ASIZE-1:0]   o_wraddress,
    output logic [DSIZE-1:0]   o_data,
    output logic               o_busy,
    output logic               o_done
);

    state_e               state_q, state_d;
    logic [DLYW-1:0]      delay_q, delay_d;
    logic [ASIZE-1:0]     depth_q, depth_d;
    logic [DECIM_W-1:0]   decim_q, decim_d;
    logic [DLYW-1:0]      dly_cnt_q, dly_cnt_d;
    logic [DECIM_W-1:0]   dec_cnt_q, dec_cnt_d;
    logic [ASIZE-1:0]     addr_q, addr_d;
    logic                 wren_q, wren_d;
    logic [ASIZE-1:0]     wraddr_q, wraddr_d;
    logic [DSIZE-1:0]     data_q, data_d;
    logic                 trig_rise;
    logic                 keep_sample;
    logic                 delay_over;

    trig_edge u_trig_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_trig (i_trig),
        .o_rise (trig_rise)
    );

    // An abort in the same cycle as a valid sample suppresses that write.
    assign keep_sample = (state_q == ST_CAPTURE) && !i_abort && i_adc_valid
                         && (dec_cnt_q == decim_q);
    assign delay_over  = (dly_cnt_q == delay_q - 1'b1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_arm) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (i_abort)        state_d = ST_IDLE;
                else if (trig_rise) state_d = (delay_q == '0) ? ST_CAPTURE : ST_DELAY;
            end
            ST_DELAY: begin
                if (i_abort)         state_d = ST_IDLE;
                else if (delay_over) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (i_abort)                               state_d = ST_IDLE;
                else if (keep_sample && addr_q == depth_q) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (i_abort || i_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (state_q)
            ST_ARMED, ST_DELAY, ST_CAPTURE: o_busy = 1'b1;
            ST_DONE:                        o_done = 1'b1;
            default: begin
                o_busy = 1'b0;
                o_done = 1'b0;
            end
        endcase
    end

    // Datapath next-state: config latch, delay/decimation/address counters
    // and the registered buffer write port.
    always_comb begin
        delay_d   = delay_q;
        depth_d   = depth_q;
        decim_d   = decim_q;
        dly_cnt_d = dly_cnt_q;
        dec_cnt_d = dec_cnt_q;
        addr_d    = addr_q;
        wren_d    = 1'b0;
        wraddr_d  = wraddr_q;
        data_d    = data_q;
        case (state_q)
            ST_IDLE: begin
                if (i_arm) begin
                    delay_d = i_delay;
                    depth_d = i_depth;
                    decim_d = i_decim;
                    addr_d  = '0;
                end
            end
            ST_ARMED: begin
                if (!i_abort && trig_rise) begin
                    dly_cnt_d = '0;
                    dec_cnt_d = decim_q;
                end
            end
            ST_DELAY: begin
                dly_cnt_d = dly_cnt_q + 1'b1;
            end
            ST_CAPTURE: begin
                if (keep_sample) begin
                    wren_d    = 1'b1;
                    wraddr_d  = addr_q;
                    data_d    = i_adc_data;
                    dec_cnt_d = '0;
                    if (addr_q != depth_q) addr_d = addr_q + 1'b1;
                end else if (!i_abort && i_adc_valid) begin
                    dec_cnt_d = dec_cnt_q + 1'b1;
                end
            end
            default: begin
                wren_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            delay_q   <= '0;
            depth_q   <= '0;
            decim_q   <= '0;
            dly_cnt_q <= '0;
            dec_cnt_q <= '0;
            addr_q    <= '0;
            wren_q    <= 1'b0;
            wraddr_q  <= '0;
            data_q    <= '0;
        end else begin
            delay_q   <= delay_d;
            depth_q   <= depth_d;
            decim_q   <= decim_d;
            dly_cnt_q <= dly_cnt_d;
            dec_cnt_q <= dec_cnt_d;
            addr_q    <= addr_d;
            wren_q    <= wren_d;
            wraddr_q  <= wraddr_d;
            data_q    <= data_d;
        end
    end

    assign o_wren      = wren_q;
    assign o_wraddress = wraddr_q;
    assign o_data      = data_q;

endmodule
